// File: rtl/axi_sram_rd_slave.sv
// AXI read-only slave fronting a single-port synchronous SRAM, one burst outstanding.
// Optional address range check enabled by defining AXI_RD_RANGE_CHECK_EN.
module axi_sram_rd_slave #(
    parameter int unsigned IDS_W  = 8,
    parameter int unsigned AW_MEM = 14,
    parameter logic [31:0] LIMIT  = 32'h0000_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  ARID_S,
    input  logic [31:0]       ARADDR_S,
    input  logic [3:0]        ARLEN_S,
    input  logic [2:0]        ARSIZE_S,
    input  logic [1:0]        ARBURST_S,
    input  logic              ARVALID_S,
    output logic              ARREADY_S,
    output logic [IDS_W-1:0]  RID_S,
    output logic [31:0]       RDATA_S,
    output logic [1:0]        RRESP_S,
    output logic              RLAST_S,
    output logic              RVALID_S,
    input  logic              RREADY_S,
    output logic              CEB,
    output logic [AW_MEM-1:0] A,
    input  logic [31:0]       DO
);

    typedef enum logic [1:0] {StIdle, StFetch, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDS_W-1:0] id_q, id_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       len_q, len_d;
    logic [1:0]       burst_q, burst_d;
    logic [3:0]       beat_q, beat_d;
    logic             err_q;

    logic             ar_hs;
    logic             last_beat;
    logic             wrap_ok;
    logic [31:0]      wrap_mask;
    logic [31:0]      addr_inc;
    logic [31:0]      addr_nxt;

    assign ar_hs     = (state_q == StIdle) && ARVALID_S;
    assign last_beat = (beat_q == len_q);

    // Wrap window is (len+1)*4 bytes; only power-of-two lengths form a legal window.
    always_comb begin
        wrap_mask = {26'd0, len_q, 2'b11};
        wrap_ok   = (burst_q == 2'b10) &&
                    ((len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15));
        addr_inc  = addr_q + 32'd4;
        if (burst_q == 2'b00) begin
            addr_nxt = addr_q;
        end else if (wrap_ok) begin
            addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
        end else begin
            addr_nxt = addr_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (ARVALID_S) begin
                    id_d    = ARID_S;
                    addr_d  = ARADDR_S;
                    len_d   = ARLEN_S;
                    burst_d = ARBURST_S;
                    beat_d  = '0;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StResp;
            StResp: begin
                if (RREADY_S) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        addr_d  = addr_nxt;
                        beat_d  = beat_q + 4'd1;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef AXI_RD_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (ar_hs) begin
            err_q <= (ARADDR_S > LIMIT);
        end
    end
`else
    logic unused_limit;
    assign err_q        = 1'b0;
    assign unused_limit = ^{LIMIT, ar_hs};
`endif

    // Only 4-byte beats are supported, so the size field carries no information.
    logic unused_size;
    assign unused_size = ^ARSIZE_S;

    always_comb begin
        ARREADY_S = 1'b0;
        RVALID_S  = 1'b0;
        RLAST_S   = 1'b0;
        RID_S     = '0;
        RDATA_S   = '0;
        RRESP_S   = 2'b00;
        CEB       = 1'b1;
        A         = '0;
        unique case (state_q)
            StIdle: ARREADY_S = 1'b1;
            StFetch: begin
                CEB = err_q;
                A   = addr_q[AW_MEM+1:2];
            end
            StResp: begin
                RVALID_S = 1'b1;
                RLAST_S  = last_beat;
                RID_S    = id_q;
                RDATA_S  = err_q ? 32'd0 : DO;
                RRESP_S  = err_q ? 2'b11 : 2'b00;
            end
            default: ARREADY_S = 1'b0;
        endcase
    end

endmodule

// File: doc/axi_sram_rd_slave.md
AXI_SRAM_RD_SLAVE -- requirements
Module: axi_sram_rd_slave

Interface
REQ-001 SHALL have parameter IDS_W, default 8, slave-side ID width; the ID is carried opaquely, including the master-index bits [IDS_W-1:IDS_W-4].
REQ-002 SHALL have parameter AW_MEM, default 14, SRAM word-address width.
REQ-003 SHALL have parameter LIMIT, default 32'h0000_FFFF, highest legal byte address, used only by the range check.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 ARID_S  input  IDS_W  read-address ID.
REQ-007 ARADDR_S  input  32  byte address.
REQ-008 ARLEN_S  input  4  beats minus 1.
REQ-009 ARSIZE_S  input  3  beat size; only 3'b010 (4 bytes) is meaningful.
REQ-010 ARBURST_S  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR.
REQ-011 ARVALID_S  input  1  address valid.
REQ-012 ARREADY_S  output  1  address ready.
REQ-013 RID_S  output  IDS_W  ID of the burst being returned.
REQ-014 RDATA_S  output  32  read data.
REQ-015 RRESP_S  output  2  response: 00 OKAY, 11 DECERR.
REQ-016 RLAST_S  output  1  final beat of the burst.
REQ-017 RVALID_S  output  1  data valid.
REQ-018 RREADY_S  input  1  data ready from the interconnect.
REQ-019 CEB  output  1  SRAM chip enable, active-low; write enable is tied off outside this block.
REQ-020 A  output  AW_MEM  SRAM word address.
REQ-021 DO  input  32  SRAM data out; valid the cycle after the CEB=0 cycle and held while CEB=1.

Function
REQ-022 SHALL implement a 3-state FSM: IDLE, FETCH, RESP.
REQ-023 IDLE: ARREADY_S=1; on ARVALID_S, latch ID, address, length and burst type, clear the beat counter, then go to FETCH.
REQ-024 FETCH: drive CEB=0 and A=addr[AW_MEM+1:2] for exactly one cycle, then go to RESP.
REQ-025 RESP: RVALID_S=1, RDATA_S=DO, RID_S=latched ID, and RLAST_S=(beat==len).
REQ-026 RESP: RID_S, RDATA_S, RRESP_S and RLAST_S SHALL stay stable until RVALID_S&RREADY_S.
REQ-027 RESP handshake on the last beat: go to IDLE.
REQ-028 RESP handshake on any other beat: advance the address, increment the beat counter, and go to FETCH.
REQ-029 Latency: AR handshake at edge t gives FETCH in cycle t+1 and RVALID_S in cycle t+2. Peak throughput is 1 beat per 2 cycles.
REQ-030 Address advance by burst type:
- INCR: addr+4.
- FIXED: addr unchanged.
- WRAP: addr+4 inside a (len+1)*4-byte aligned window; lengths other than 1/3/7/15 are treated as INCR.
REQ-031 Word address A SHALL wrap modulo 2^AW_MEM; no overflow flag.
REQ-032 ARREADY_S SHALL be 0 in FETCH and RESP; only one burst is outstanding.
REQ-033 RREADY_S asserted while RVALID_S=0 SHALL have no effect.
REQ-034 A single-beat burst (len=0) SHALL assert RLAST_S on its only beat.

Reset
REQ-035 While rst=0, outputs SHALL be: state IDLE, ARREADY_S=1, RVALID_S=0, RLAST_S=0, RID_S=0, RRESP_S=0, CEB=1, A=0; all latched fields and the beat counter are 0.
REQ-036 Reset during FETCH or RESP SHALL abort the burst immediately, without RLAST_S, and the next burst SHALL start cleanly.

Configuration
REQ-037 Macro AXI_RD_RANGE_CHECK_EN, when defined:
- ARADDR_S>LIMIT at AR handshake sets an error flag for the whole burst.
- While the flag is set: CEB stays 1, RDATA_S=0 and RRESP_S=2'b11 on every beat.
- Beat count, RLAST_S and FSM timing are unchanged.
REQ-038 Macro AXI_RD_RANGE_CHECK_EN undefined: no check is made, RRESP_S is always 2'b00, and LIMIT is unused.

Verification
REQ-039 INCR, ARID=8'h12, ADDR=0x100, LEN=3, RREADY=1 -> CEB low at A=0x40,0x41,0x42,0x43; 4 beats, RID=0x12, RLAST on beat 4; first RVALID 2 cycles after AR.
REQ-040 WRAP, ADDR=0x10C, LEN=3 -> A=0x43,0x40,0x41,0x42.
REQ-041 FIXED, LEN=2, RREADY held 0 for 3 cycles on beat 1 -> A=0x40 every beat; RVALID/RDATA stable during stall; ARREADY=0 until after RLAST.
REQ-042 rst pulsed low during beat 2 of a LEN=7 burst -> RVALID=0 and ARREADY=1 immediately; the next AR is served from beat 0.
REQ-043 With AXI_RD_RANGE_CHECK_EN, ADDR=0x0001_0000, LEN=1 -> 2 beats with RRESP=2'b11 and RDATA=0, CEB never low; without it -> RRESP=2'b00 and A wraps to 0x0000.
